// File: rtl/datapath_if.sv
// datapath_if: control, memory and debug signals between a controller and the datapath
interface datapath_if;
  logic        IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite;
  logic        MemRead, MemWrite, MemToReg, AddrSel;
  logic [1:0]  ALUSrcA, ALUSrcB;
  logic [2:0]  ALUOp;
  logic        PCWrite;
  logic [1:0]  PCSel;
  logic        Halt;
  logic [3:0]  opcode;
  logic        zero;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic        halted;
  logic [1:0]  dbg_sel;
  logic [15:0] dbg_reg;
  modport master (
    output IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite,
           MemRead, MemWrite, MemToReg, AddrSel, ALUSrcA, ALUSrcB, ALUOp,
           PCWrite, PCSel, Halt, mem_rdata, dbg_sel,
    input  opcode, zero, mem_addr, mem_wdata, mem_we, mem_re, halted, dbg_reg
  );
  modport slave (
    input  IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite,
           MemRead, MemWrite, MemToReg, AddrSel, ALUSrcA, ALUSrcB, ALUOp,
           PCWrite, PCSel, Halt, mem_rdata, dbg_sel,
    output opcode, zero, mem_addr, mem_wdata, mem_we, mem_re, halted, dbg_reg
  );
endinterface

// File: rtl/datapath.sv
// datapath: 16-bit multicycle datapath sequenced entirely by external control inputs
module datapath (
  input logic       clk,
  input logic       reset,
  datapath_if.slave bus
);
  logic [7:0]  r_pc;
  logic [15:0] r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [15:0] r_rf [4];
  logic        r_halted;
  logic        w_frz;
  logic [15:0] w_opa, w_opb, w_alu, w_wb;
  logic [7:0]  w_pc_next;
  // operand muxes, ALU, PC source and writeback source
  always_comb begin
    w_frz = bus.Halt | r_halted;
    w_opa = bus.ALUSrcA[1] ? 16'h0000 : bus.ALUSrcA[0] ? r_a : {8'h00, r_pc};
    w_opb = bus.ALUSrcB == 2'd0 ? r_b :
            bus.ALUSrcB == 2'd1 ? 16'd1 :
            bus.ALUSrcB == 2'd2 ? {8'h00, r_ir[7:0]} : 16'h0000;
    w_alu = bus.ALUOp == 3'd0 ? w_opa + w_opb :
            bus.ALUOp == 3'd1 ? w_opa - w_opb :
            bus.ALUOp == 3'd2 ? w_opa & w_opb :
            bus.ALUOp == 3'd3 ? w_opa | w_opb :
            bus.ALUOp == 3'd4 ? w_opa ^ w_opb :
            bus.ALUOp == 3'd5 ? w_opb : 16'h0000;
    // an 8-bit add of the raw offset equals adding its sign extension modulo 256
    w_pc_next = bus.PCSel == 2'd0 ? w_alu[7:0] :
                bus.PCSel == 2'd1 ? r_pc + r_ir[7:0] :
                bus.PCSel == 2'd2 ? r_ir[7:0] : r_pc;
    w_wb = bus.MemToReg ? r_mdr : r_aluout;
  end
  assign bus.opcode    = r_ir[15:12];
  assign bus.zero      = r_a == 16'h0000;
  assign bus.mem_addr  = bus.AddrSel ? r_aluout[7:0] : r_pc;
  assign bus.mem_wdata = r_b;
  assign bus.mem_we    = bus.MemWrite & ~r_halted & ~bus.Halt;
  assign bus.mem_re    = bus.MemRead & ~bus.MemWrite & ~r_halted;
  assign bus.halted    = r_halted;
  assign bus.dbg_reg   = r_rf[bus.dbg_sel];
  // architectural state: loads honoured only while not halting, halt flag sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_halted <= 1'b0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      r_halted <= r_halted | bus.Halt;
      if (!w_frz) begin
        if (bus.IRload) r_ir <= bus.mem_rdata;
        if (bus.MDRload) r_mdr <= bus.mem_rdata;
        if (bus.Aload) r_a <= r_rf[r_ir[11:10]];
        if (bus.Bload) r_b <= r_rf[r_ir[9:8]];
        if (bus.ALUOutLoad) r_aluout <= w_alu;
        if (bus.PCWrite) r_pc <= w_pc_next;
        if (bus.RegWrite) r_rf[r_ir[11:10]] <= w_wb;
      end
    end
  end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed and randomized checks of datapath against a behavioural model
module tb_datapath;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  datapath_if dp ();
  datapath dut (.clk(clk), .reset(reset), .bus(dp));
  always #5 clk = ~clk;
  logic [7:0]  m_pc;
  logic [15:0] m_ir, m_a, m_b, m_alu, m_mdr;
  logic [15:0] m_r [4];
  logic        m_halted;
  task automatic idle;
    {dp.IRload, dp.Aload, dp.Bload, dp.ALUOutLoad, dp.MDRload, dp.RegWrite} = '0;
    {dp.MemRead, dp.MemWrite, dp.MemToReg, dp.AddrSel, dp.PCWrite, dp.Halt} = '0;
    dp.ALUSrcA = 2'd0; dp.ALUSrcB = 2'd0; dp.ALUOp = 3'd0; dp.PCSel = 2'd0;
    dp.mem_rdata = 16'h0; dp.dbg_sel = 2'd0;
  endtask
  task automatic model_step;
    int a, b, res, pcn;
    if (reset) begin
      m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_alu = 0; m_mdr = 0; m_halted = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      return;
    end
    if (dp.Halt || m_halted) begin
      m_halted = 1;
      return;
    end
    case (dp.ALUSrcA)
      2'd0: a = int'(m_pc);
      2'd1: a = int'(m_a);
      default: a = 0;
    endcase
    case (dp.ALUSrcB)
      2'd0: b = int'(m_b);
      2'd1: b = 1;
      2'd2: b = int'(m_ir[7:0]);
      default: b = 0;
    endcase
    case (dp.ALUOp)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = b;
      default: res = 0;
    endcase
    res = res & 'hFFFF;
    case (dp.PCSel)
      2'd0: pcn = res & 255;
      2'd1: pcn = (int'(m_pc) + int'($signed(m_ir[7:0]))) & 255;
      2'd2: pcn = int'(m_ir[7:0]);
      default: pcn = int'(m_pc);
    endcase
    if (dp.Aload) m_a = m_r[m_ir[11:10]];
    if (dp.Bload) m_b = m_r[m_ir[9:8]];
    if (dp.RegWrite) m_r[m_ir[11:10]] = dp.MemToReg ? m_mdr : m_alu;
    if (dp.ALUOutLoad) m_alu = res[15:0];
    if (dp.MDRload) m_mdr = dp.mem_rdata;
    if (dp.IRload) m_ir = dp.mem_rdata;
    if (dp.PCWrite) m_pc = pcn[7:0];
  endtask
  task automatic tick;
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic load_ir(input logic [15:0] v);
    dp.mem_rdata = v; dp.IRload = 1'b1;
    tick();
  endtask
  task automatic test_reset;
    reset = 1'b1;
    dp.Halt = 1'b1; dp.PCWrite = 1'b1; dp.PCSel = 2'd2; dp.RegWrite = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (dp.opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=0", dp.opcode); end
    checks++; if (dp.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", dp.zero); end
    checks++; if (dp.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", dp.halted); end
    checks++; if (dp.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", dp.mem_addr); end
    for (int i = 0; i < 4; i++) begin
      dp.dbg_sel = 2'(i); #1;
      checks++; if (dp.dbg_reg !== 16'h0) begin errors++; $display("FAIL reset_r%0d got=%h exp=0000", i, dp.dbg_reg); end
    end
    idle();
  endtask
  task automatic test_fetch;
    dp.mem_rdata = 16'h5407; dp.IRload = 1'b1; dp.ALUSrcA = 2'd0; dp.ALUSrcB = 2'd1;
    dp.ALUOp = 3'd0; dp.PCWrite = 1'b1; dp.PCSel = 2'd0;
    tick();
    checks++; if (dp.opcode !== 4'h5) begin errors++; $display("FAIL fetch_opcode got=%h exp=5", dp.opcode); end
    checks++; if (dp.mem_addr !== 8'h01) begin errors++; $display("FAIL fetch_pc got=%h exp=01", dp.mem_addr); end
  endtask
  task automatic test_ldi;
    dp.ALUSrcB = 2'd2; dp.ALUOp = 3'd5; dp.ALUOutLoad = 1'b1;
    tick();
    dp.AddrSel = 1'b1; #1;
    checks++; if (dp.mem_addr !== 8'h07) begin errors++; $display("FAIL ldi_aluout got=%h exp=07", dp.mem_addr); end
    dp.RegWrite = 1'b1; dp.MemToReg = 1'b0;
    tick();
    dp.dbg_sel = 2'd1; #1;
    checks++; if (dp.dbg_reg !== 16'h0007) begin errors++; $display("FAIL ldi_r1 got=%h exp=0007", dp.dbg_reg); end
  endtask
  task automatic test_add_sub;
    load_ir(16'h0000);
    dp.ALUSrcA = 2'd2; dp.ALUSrcB = 2'd1; dp.ALUOp = 3'd1; dp.ALUOutLoad = 1'b1; tick();
    dp.RegWrite = 1'b1; tick();
    load_ir(16'h0400);
    dp.ALUSrcA = 2'd2; dp.ALUSrcB = 2'd1; dp.ALUOp = 3'd0; dp.ALUOutLoad = 1'b1; tick();
    dp.RegWrite = 1'b1; tick();
    load_ir(16'h0100);
    dp.Aload = 1'b1; dp.Bload = 1'b1; tick();
    checks++; if (dp.zero !== 1'b0) begin errors++; $display("FAIL add_zero_a got=%b exp=0", dp.zero); end
    checks++; if (dp.mem_wdata !== 16'h0001) begin errors++; $display("FAIL add_b got=%h exp=0001", dp.mem_wdata); end
    dp.ALUSrcA = 2'd1; dp.ALUSrcB = 2'd0; dp.ALUOp = 3'd0; dp.ALUOutLoad = 1'b1; tick();
    dp.RegWrite = 1'b1; dp.Aload = 1'b1; tick();
    checks++; if (dp.zero !== 1'b0) begin errors++; $display("FAIL add_read_old got=%b exp=0", dp.zero); end
    checks++; if (dp.dbg_reg !== 16'h0000) begin errors++; $display("FAIL add_wrap_r0 got=%h exp=0000", dp.dbg_reg); end
    dp.Aload = 1'b1; tick();
    checks++; if (dp.zero !== 1'b1) begin errors++; $display("FAIL add_zero got=%b exp=1", dp.zero); end
    dp.ALUSrcA = 2'd1; dp.ALUSrcB = 2'd0; dp.ALUOp = 3'd1; dp.ALUOutLoad = 1'b1; tick();
    dp.RegWrite = 1'b1; tick();
    checks++; if (dp.dbg_reg !== 16'hFFFF) begin errors++; $display("FAIL sub_wrap_r0 got=%h exp=FFFF", dp.dbg_reg); end
  endtask
  task automatic test_ld_st;
    load_ir(16'h0F40);
    dp.MemRead = 1'b1; dp.mem_rdata = 16'h1234; dp.MDRload = 1'b1; tick();
    dp.RegWrite = 1'b1; dp.MemToReg = 1'b1; tick();
    dp.Bload = 1'b1; tick();
    dp.ALUSrcB = 2'd2; dp.ALUOp = 3'd5; dp.ALUOutLoad = 1'b1; tick();
    dp.AddrSel = 1'b1; dp.MemWrite = 1'b1; dp.MemRead = 1'b1; #1;
    checks++; if (dp.mem_addr !== 8'h40) begin errors++; $display("FAIL st_addr got=%h exp=40", dp.mem_addr); end
    checks++; if (dp.mem_we !== 1'b1) begin errors++; $display("FAIL st_we got=%b exp=1", dp.mem_we); end
    checks++; if (dp.mem_wdata !== 16'h1234) begin errors++; $display("FAIL st_wdata got=%h exp=1234", dp.mem_wdata); end
    checks++; if (dp.mem_re !== 1'b0) begin errors++; $display("FAIL st_re_priority got=%b exp=0", dp.mem_re); end
    dp.MemWrite = 1'b0; #1;
    checks++; if (dp.mem_re !== 1'b1) begin errors++; $display("FAIL ld_re got=%b exp=1", dp.mem_re); end
    checks++; if (dp.mem_we !== 1'b0) begin errors++; $display("FAIL ld_we got=%b exp=0", dp.mem_we); end
    dp.mem_rdata = 16'hBEEF; dp.MDRload = 1'b1; tick();
    dp.RegWrite = 1'b1; dp.MemToReg = 1'b1; tick();
    dp.dbg_sel = 2'd3; #1;
    checks++; if (dp.dbg_reg !== 16'hBEEF) begin errors++; $display("FAIL ld_r3 got=%h exp=BEEF", dp.dbg_reg); end
  endtask
  task automatic test_branch;
    load_ir(16'h0005);
    dp.PCWrite = 1'b1; dp.PCSel = 2'd2; tick();
    checks++; if (dp.mem_addr !== 8'h05) begin errors++; $display("FAIL jmp_05 got=%h exp=05", dp.mem_addr); end
    load_ir(16'h00FE);
    dp.PCWrite = 1'b1; dp.PCSel = 2'd1; tick();
    checks++; if (dp.mem_addr !== 8'h03) begin errors++; $display("FAIL br_back got=%h exp=03", dp.mem_addr); end
    load_ir(16'h0080);
    dp.PCWrite = 1'b1; dp.PCSel = 2'd2; tick();
    checks++; if (dp.mem_addr !== 8'h80) begin errors++; $display("FAIL jmp_80 got=%h exp=80", dp.mem_addr); end
    dp.PCWrite = 1'b1; dp.PCSel = 2'd3; tick();
    checks++; if (dp.mem_addr !== 8'h80) begin errors++; $display("FAIL pc_hold got=%h exp=80", dp.mem_addr); end
    load_ir(16'h00FF);
    dp.PCWrite = 1'b1; dp.PCSel = 2'd2; tick();
    dp.ALUSrcA = 2'd0; dp.ALUSrcB = 2'd1; dp.ALUOp = 3'd0; dp.PCWrite = 1'b1; dp.PCSel = 2'd0; tick();
    checks++; if (dp.mem_addr !== 8'h00) begin errors++; $display("FAIL pc_wrap got=%h exp=00", dp.mem_addr); end
  endtask
  task automatic test_halt;
    dp.Halt = 1'b1; dp.PCWrite = 1'b1; dp.PCSel = 2'd2; dp.RegWrite = 1'b1; dp.MemWrite = 1'b1;
    dp.IRload = 1'b1; dp.mem_rdata = 16'hA000; #1;
    checks++; if (dp.mem_we !== 1'b0) begin errors++; $display("FAIL halt_we got=%b exp=0", dp.mem_we); end
    tick();
    checks++; if (dp.mem_addr !== 8'h00) begin errors++; $display("FAIL halt_pc got=%h exp=00", dp.mem_addr); end
    checks++; if (dp.opcode !== 4'h0) begin errors++; $display("FAIL halt_ir got=%h exp=0", dp.opcode); end
    for (int i = 0; i < 10; i++) begin
      {dp.IRload, dp.Aload, dp.Bload, dp.ALUOutLoad, dp.MDRload, dp.RegWrite} = 6'($urandom);
      dp.PCWrite = 1'b1; dp.PCSel = 2'd2; dp.MemWrite = 1'b1; dp.mem_rdata = 16'($urandom);
      #1;
      checks++; if (dp.halted !== 1'b1 || dp.mem_we !== 1'b0) begin errors++; $display("FAIL halt_sticky cycle %0d got halted=%b we=%b exp 1/0", i, dp.halted, dp.mem_we); end
      tick();
    end
    dp.dbg_sel = 2'd3; #1;
    checks++; if (dp.dbg_reg !== 16'hBEEF) begin errors++; $display("FAIL halt_r3 got=%h exp=BEEF", dp.dbg_reg); end
    checks++; if (dp.mem_addr !== 8'h00) begin errors++; $display("FAIL halt_pc_end got=%h exp=00", dp.mem_addr); end
    test_reset();
  endtask
  task automatic test_random;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      {dp.IRload, dp.Aload, dp.Bload, dp.ALUOutLoad, dp.MDRload, dp.RegWrite} = 6'($urandom);
      {dp.MemRead, dp.MemWrite, dp.MemToReg, dp.AddrSel, dp.PCWrite} = 5'($urandom);
      dp.ALUSrcA = 2'($urandom); dp.ALUSrcB = 2'($urandom); dp.ALUOp = 3'($urandom);
      dp.PCSel = 2'($urandom); dp.dbg_sel = 2'($urandom); dp.mem_rdata = 16'($urandom);
      dp.Halt = ($urandom_range(0, 79) == 0);
      reset = ($urandom_range(0, 39) == 0);
      #1;
      checks++; if (dp.opcode !== m_ir[15:12]) begin errors++; $display("FAIL rnd_opcode n=%0d got=%h exp=%h", n, dp.opcode, m_ir[15:12]); end
      checks++; if (dp.zero !== (m_a == 16'h0)) begin errors++; $display("FAIL rnd_zero n=%0d got=%b exp=%b", n, dp.zero, m_a == 16'h0); end
      checks++; if (dp.mem_addr !== (dp.AddrSel ? m_alu[7:0] : m_pc)) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, dp.mem_addr, dp.AddrSel ? m_alu[7:0] : m_pc); end
      checks++; if (dp.mem_wdata !== m_b) begin errors++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, dp.mem_wdata, m_b); end
      checks++; if (dp.mem_we !== (dp.MemWrite && !m_halted && !dp.Halt)) begin errors++; $display("FAIL rnd_we n=%0d got=%b", n, dp.mem_we); end
      checks++; if (dp.mem_re !== (dp.MemRead && !dp.MemWrite && !m_halted)) begin errors++; $display("FAIL rnd_re n=%0d got=%b", n, dp.mem_re); end
      checks++; if (dp.halted !== m_halted) begin errors++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, dp.halted, m_halted); end
      checks++; if (dp.dbg_reg !== m_r[dp.dbg_sel]) begin errors++; $display("FAIL rnd_dbg n=%0d r%0d got=%h exp=%h", n, dp.dbg_sel, dp.dbg_reg, m_r[dp.dbg_sel]); end
      tick();
    end
    reset = 1'b0;
  endtask
  initial begin
    idle();
    reset = 1'b0;
    test_reset();
    test_fetch();
    test_ldi();
    test_add_sub();
    test_ld_st();
    test_branch();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
